// File: rtl/lpffir_pkg.sv
// rtl/lpffir_pkg.sv - shared widths and sample type for the moving-sum FIR
package lpffir_pkg;

  localparam int DATA_W = 16;
  localparam int NTAPS  = 6;

  typedef logic [DATA_W-1:0] sample_t;

endpackage

// File: rtl/lpffir_core.sv
// rtl/lpffir_core.sv - 6-tap unity-coefficient delay line and adder tree
module lpffir_core
  import lpffir_pkg::*;
(
  input  logic    aclk_i,
  input  logic    aresetn_i,
  input  logic    shift_en_i,
  input  sample_t x0_i,
  output sample_t sum_o
);

  // x1 is the newest stored sample, x5 the oldest; names kept flat for probing.
  sample_t x0;
  sample_t x1;
  sample_t x2;
  sample_t x3;
  sample_t x4;
  sample_t x5;

  sample_t h0;
  sample_t h1;
  sample_t h2;
  sample_t h01;

  assign x0 = x0_i;

  // Shift the history on every accepted sample; reset wins over a shift.
  always_ff @(posedge aclk_i) begin
    if (aresetn_i) begin
      x1 <= '0;
      x2 <= '0;
      x3 <= '0;
      x4 <= '0;
      x5 <= '0;
    end else if (shift_en_i) begin
      x5 <= x4;
      x4 <= x3;
      x3 <= x2;
      x2 <= x1;
      x1 <= x0;
    end
  end

  // Balanced pairwise tree; every sum wraps at the sample width.
  always_comb begin
    h0    = x0 + x1;
    h1    = x2 + x3;
    h2    = x4 + x5;
    h01   = h0 + h1;
    sum_o = h01 + h2;
  end

endmodule

// File: rtl/lpffir_axis.sv
// rtl/lpffir_axis.sv - zero-latency AXI-Stream wrapper around the moving-sum core
module lpffir_axis
  import lpffir_pkg::*;
(
  input  logic              aclk_i,
  input  logic              aresetn_i,
  input  logic [DATA_W-1:0] rx_tdata_i,
  input  logic              rx_tvalid_i,
  input  logic              rx_tlast_i,
  output logic              rx_tready_o,
  output logic [DATA_W-1:0] tx_tdata_o,
  output logic              tx_tvalid_o,
  output logic              tx_tlast_o,
  input  logic              tx_tready_i
);

  logic    w_shift_en;
  sample_t w_sum;

  // Handshake passes straight through; a transfer on rx is a transfer on tx.
  always_comb begin
    rx_tready_o = tx_tready_i & ~aresetn_i;
    tx_tvalid_o = rx_tvalid_i & ~aresetn_i;
    tx_tlast_o  = rx_tlast_i;
    w_shift_en  = rx_tvalid_i & rx_tready_o;
    tx_tdata_o  = w_sum;
  end

  lpffir_core core (
    .aclk_i     (aclk_i),
    .aresetn_i  (aresetn_i),
    .shift_en_i (w_shift_en),
    .x0_i       (rx_tdata_i),
    .sum_o      (w_sum)
  );

endmodule

// File: tb/tb_lpffir_axis.sv
// tb/tb_lpffir_axis.sv - directed and modelled checks for lpffir_axis
module tb_lpffir_axis;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [15:0] rx_tdata = '0;
  logic        rx_tvalid = 1'b0;
  logic        rx_tlast = 1'b0;
  logic        tx_tready = 1'b0;
  logic        rx_tready;
  logic [15:0] tx_tdata;
  logic        tx_tvalid;
  logic        tx_tlast;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  lpffir_axis dut (
    .aclk_i      (aclk),
    .aresetn_i   (aresetn),
    .rx_tdata_i  (rx_tdata),
    .rx_tvalid_i (rx_tvalid),
    .rx_tlast_i  (rx_tlast),
    .rx_tready_o (rx_tready),
    .tx_tdata_o  (tx_tdata),
    .tx_tvalid_o (tx_tvalid),
    .tx_tlast_o  (tx_tlast),
    .tx_tready_i (tx_tready)
  );

  function automatic logic [79:0] line_state();
    return {dut.core.x1, dut.core.x2, dut.core.x3, dut.core.x4, dut.core.x5};
  endfunction

  task automatic drive(input logic [15:0] d, input logic v, input logic l, input logic r);
    @(negedge aclk);
    rx_tdata = d; rx_tvalid = v; rx_tlast = l; tx_tready = r;
    #1;
  endtask

  task automatic reset_cycles(input int n);
    @(negedge aclk);
    aresetn = 1'b1; rx_tvalid = 1'b0;
    repeat (n) @(posedge aclk);
    #2;
    aresetn = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b1; tx_tready = 1'b1; rx_tvalid = 1'b0; rx_tdata = 16'd123;
    repeat (2) @(posedge aclk);
    #2;
    checks++; if (rx_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", rx_tready); end
    checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tx_tvalid); end
    checks++; if (line_state() !== 80'd0) begin errors++; $display("FAIL reset_line got %h want 0", line_state()); end
    checks++; if (tx_tdata !== 16'd123) begin errors++; $display("FAIL reset_tdata got %0d want 123", tx_tdata); end
    rx_tvalid = 1'b1; #1;
    checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid_in got %b want 0", tx_tvalid); end
    rx_tvalid = 1'b0;
  endtask

  task automatic test_stream();
    logic [15:0] s_in  [7] = '{16'd50, 16'd60, 16'd70, 16'd80, 16'd90, 16'd100, 16'd110};
    logic [15:0] s_exp [7] = '{16'd50, 16'd110, 16'd180, 16'd260, 16'd350, 16'd450, 16'd510};
    @(negedge aclk);
    aresetn = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(s_in[i], 1'b1, 1'b0, 1'b1);
      checks++; if (tx_tdata !== s_exp[i]) begin errors++; $display("FAIL stream_data[%0d] got %0d want %0d", i, tx_tdata, s_exp[i]); end
      checks++; if (tx_tvalid !== 1'b1 || rx_tready !== 1'b1) begin errors++; $display("FAIL stream_hs[%0d] got v=%b r=%b want 1 1", i, tx_tvalid, rx_tready); end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] w_exp [7] = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB, 16'hFFFA, 16'hFFFA};
    reset_cycles(1);
    for (int i = 0; i < 7; i++) begin
      drive(16'hFFFF, 1'b1, 1'b0, 1'b1);
      checks++; if (tx_tdata !== w_exp[i]) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, tx_tdata, w_exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    reset_cycles(1);
    for (int i = 1; i <= 5; i++) drive(16'(i), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(16'd1000, 1'b1, 1'b0, 1'b0);
      checks++; if (rx_tready !== 1'b0) begin errors++; $display("FAIL bp_tready[%0d] got %b want 0", i, rx_tready); end
      checks++; if (tx_tdata !== 16'd1015) begin errors++; $display("FAIL bp_data[%0d] got %0d want 1015", i, tx_tdata); end
    end
    drive(16'd1000, 1'b1, 1'b0, 1'b1);
    checks++; if (line_state() !== {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}) begin errors++; $display("FAIL bp_hold got %h want 00050004000300020001", line_state()); end
    checks++; if (tx_tdata !== 16'd1015 || rx_tready !== 1'b1) begin errors++; $display("FAIL bp_release got d=%0d r=%b want 1015 1", tx_tdata, rx_tready); end
    drive(16'd6, 1'b1, 1'b0, 1'b1);
    checks++; if (dut.core.x1 !== 16'd1000 || dut.core.x2 !== 16'd5) begin errors++; $display("FAIL bp_one_shift got x1=%0d x2=%0d want 1000 5", dut.core.x1, dut.core.x2); end
    checks++; if (tx_tdata !== 16'd1020) begin errors++; $display("FAIL bp_next got %0d want 1020", tx_tdata); end
  endtask

  task automatic test_idle_last();
    for (int i = 0; i < 5; i++) begin
      drive(16'd0, 1'b0, 1'b0, 1'b1);
      checks++; if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL idle_tvalid[%0d] got %b want 0", i, tx_tvalid); end
    end
    drive(16'd10, 1'b1, 1'b1, 1'b1);
    checks++; if (dut.core.x1 !== 16'd6 || dut.core.x2 !== 16'd1000) begin errors++; $display("FAIL idle_hold got x1=%0d x2=%0d want 6 1000", dut.core.x1, dut.core.x2); end
    checks++; if (tx_tlast !== 1'b1) begin errors++; $display("FAIL last_out got %b want 1", tx_tlast); end
    checks++; if (tx_tdata !== 16'd1028) begin errors++; $display("FAIL last_data got %0d want 1028", tx_tdata); end
    drive(16'd0, 1'b1, 1'b0, 1'b1);
    checks++; if (tx_tlast !== 1'b0 || tx_tdata !== 16'd1025) begin errors++; $display("FAIL carry_over got l=%b d=%0d want 0 1025", tx_tlast, tx_tdata); end
    drive(16'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random_reset();
    logic [15:0] h [5];
    logic [15:0] d;
    logic [15:0] exp_d;
    logic        v, r;
    int          bad = 0;
    reset_cycles(1);
    for (int k = 0; k < 5; k++) h[k] = '0;
    for (int i = 0; i < 101; i++) begin
      d = 16'($urandom);
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      drive(d, v, 1'b0, r);
      exp_d = d + h[0] + h[1] + h[2] + h[3] + h[4];
      checks++;
      if (tx_tdata !== exp_d || tx_tvalid !== v || rx_tready !== r) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL rand[%0d] got d=%h v=%b r=%b want d=%h v=%b r=%b", i, tx_tdata, tx_tvalid, rx_tready, exp_d, v, r);
      end
      if (v && r) begin
        for (int k = 4; k > 0; k--) h[k] = h[k-1];
        h[0] = d;
      end
    end
    @(negedge aclk);
    aresetn = 1'b1; rx_tvalid = 1'b1; tx_tready = 1'b1;
    @(posedge aclk);
    #2;
    checks++; if (line_state() !== 80'd0) begin errors++; $display("FAIL midreset_line got %h want 0", line_state()); end
    aresetn = 1'b0;
    drive(16'd7, 1'b1, 1'b0, 1'b1);
    checks++; if (tx_tdata !== 16'd7) begin errors++; $display("FAIL midreset_first got %0d want 7", tx_tdata); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_backpressure();
    test_idle_last();
    test_random_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
